// File: rtl/mem_sram_pkg.sv
// Shared types, defaults and helpers for the MEM-stage SRAM controller.
// Used by mem_sram_ctrl and, under MEM_SRAM_CTRL_POST_WR_EN, by mem_sram_wbuf.
package mem_sram_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_SRAM_DW  = 16;
    localparam int DEF_SRAM_AW  = 18;
    localparam int DEF_WAIT_CYC = 2;
    localparam int DEF_BASE_ADR = 1024;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    // Number of SRAM beats needed to move one processor word.
    function automatic int beats_f(input int data_w, input int sram_dw);
        return data_w / sram_dw;
    endfunction

endpackage

// File: rtl/mem_sram_wbuf.sv
// Posted-write buffer: one address+data entry with a valid flag.
// Only instantiated when MEM_SRAM_CTRL_POST_WR_EN is defined.
module mem_sram_wbuf #(
    parameter int AW = 18,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic          clear_i,
    input  logic [AW-1:0] adr_i,
    input  logic [DW-1:0] data_i,
    output logic          valid_o,
    output logic [AW-1:0] adr_o,
    output logic [DW-1:0] data_o
);

    logic          valid_q;
    logic [AW-1:0] adr_q;
    logic [DW-1:0] data_q;

    // Entry register; a load wins over a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            adr_q   <= '0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            adr_q   <= adr_i;
            data_q  <= data_i;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_q;
        end
    end

    assign valid_o = valid_q;
    assign adr_o   = adr_q;
    assign data_o  = data_q;

endmodule

// File: rtl/mem_sram_ctrl.sv
// MEM-stage controller: splits word requests into wait-stated beats on an async SRAM.
// Define MEM_SRAM_CTRL_POST_WR_EN to enable a one-entry posted write buffer.
module mem_sram_ctrl
    import mem_sram_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int SRAM_DW  = DEF_SRAM_DW,
    parameter int SRAM_AW  = DEF_SRAM_AW,
    parameter int WAIT_CYC = DEF_WAIT_CYC,
    parameter int BASE_ADR = DEF_BASE_ADR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        adr,
    input  logic [DATA_W-1:0]  wr_data,
    output logic [DATA_W-1:0]  rd_data,
    output logic               ready,
    inout  wire  [SRAM_DW-1:0] SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_adr,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N,
    output logic               SRAM_WE_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_OE_N
);

    localparam int BEATS = beats_f(DATA_W, SRAM_DW);
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WW    = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [BW-1:0] BEAT_ONE  = BW'(1);
    localparam logic [WW-1:0] LAST_WAIT = WW'(WAIT_CYC - 1);
    localparam logic [WW-1:0] WAIT_ONE  = WW'(1);
    localparam logic [31:0]   BASE      = 32'(BASE_ADR);

    state_e               state_q, state_d;
    logic [BW-1:0]        beat_q, beat_d;
    logic [WW-1:0]        wait_q, wait_d;
    logic                 op_wr_q, op_wr_d;
    logic [SRAM_AW-1:0]   base_q, base_d;
    logic [DATA_W-1:0]    rd_data_q, rd_data_d;
    logic                 ce_n_q, ce_n_d;
    logic                 we_n_q, we_n_d;
    logic                 oe_n_q, oe_n_d;
    logic                 lane_n_q, lane_n_d;
    logic                 dq_oe_q, dq_oe_d;
    logic [SRAM_DW-1:0]   dq_out_q, dq_out_d;
    logic [SRAM_AW-1:0]   sram_adr_q, sram_adr_d;

    logic                 req_s;
    logic                 start_s;
    logic                 acc_d_s;
    logic [31:0]          offset_s;
    logic [SRAM_AW-1:0]   word_base_s;
    logic [SRAM_AW-1:0]   held_base_s;
    logic [DATA_W-1:0]    held_wdata_s;
    logic [SRAM_AW-1:0]   cur_base_s;
    logic [DATA_W-1:0]    cur_wdata_s;

    assign req_s       = wr_en | rd_en;
    assign start_s     = (state_q == IDLE) & req_s;
    assign offset_s    = adr - BASE;
    assign word_base_s = SRAM_AW'((offset_s >> 2) * 32'(BEATS));

`ifdef MEM_SRAM_CTRL_POST_WR_EN
    logic                 wb_valid_s;
    logic [SRAM_AW-1:0]   wb_adr_s;
    logic [DATA_W-1:0]    wb_data_s;

    mem_sram_wbuf #(
        .AW (SRAM_AW),
        .DW (DATA_W)
    ) u_wbuf (
        .clk     (clk),
        .rst_n   (rst),
        .load_i  (start_s & wr_en),
        .clear_i ((state_q == DONE) & op_wr_q),
        .adr_i   (word_base_s),
        .data_i  (wr_data),
        .valid_o (wb_valid_s),
        .adr_o   (wb_adr_s),
        .data_o  (wb_data_s)
    );

    assign held_wdata_s = wb_data_s;
    assign held_base_s  = op_wr_q ? wb_adr_s : base_q;
    // A write taken in IDLE completes for the requester at once; anything else waits for the drain.
    assign ready = ((state_q == IDLE) & wr_en) ? 1'b1 :
                   (wb_valid_s ? ~req_s : (~req_s | (state_q == DONE)));
`else
    logic [DATA_W-1:0]    wdata_q;

    // Write data held for the duration of a blocking access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdata_q <= '0;
        end else if (start_s) begin
            wdata_q <= wr_data;
        end else begin
            wdata_q <= wdata_q;
        end
    end

    assign held_wdata_s = wdata_q;
    assign held_base_s  = base_q;
    assign ready        = ~req_s | (state_q == DONE);
`endif

    // In IDLE the next beat comes straight from the request; later beats use latched values.
    assign cur_base_s  = (state_q == IDLE) ? word_base_s : held_base_s;
    assign cur_wdata_s = (state_q == IDLE) ? wr_data : held_wdata_s;

    // Next state, counters, read capture and the registered SRAM pin values.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        wait_d    = wait_q;
        op_wr_d   = op_wr_q;
        base_d    = base_q;
        rd_data_d = rd_data_q;
        case (state_q)
            IDLE: begin
                if (start_s) begin
                    state_d = ACCESS;
                    beat_d  = '0;
                    wait_d  = '0;
                    op_wr_d = wr_en;
                    base_d  = word_base_s;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (wait_q == LAST_WAIT) begin
                    wait_d = '0;
                    if (!op_wr_q) begin
                        rd_data_d[int'(beat_q)*SRAM_DW +: SRAM_DW] = SRAM_DQ;
                    end else begin
                        rd_data_d = rd_data_q;
                    end
                    if (beat_q == LAST_BEAT) begin
                        state_d = DONE;
                    end else begin
                        beat_d = beat_q + BEAT_ONE;
                    end
                end else begin
                    wait_d = wait_q + WAIT_ONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                beat_d  = '0;
                wait_d  = '0;
            end
            default: begin
                state_d = IDLE;
                beat_d  = '0;
                wait_d  = '0;
            end
        endcase

        // Pins are decoded from the next state so they are registered yet aligned with it.
        acc_d_s    = (state_d == ACCESS);
        ce_n_d     = ~acc_d_s;
        lane_n_d   = ~acc_d_s;
        oe_n_d     = ~(acc_d_s & ~op_wr_d);
        we_n_d     = ~(acc_d_s & op_wr_d & (wait_d != LAST_WAIT));
        dq_oe_d    = acc_d_s & op_wr_d;
        dq_out_d   = cur_wdata_s[int'(beat_d)*SRAM_DW +: SRAM_DW];
        sram_adr_d = cur_base_s + SRAM_AW'(beat_d);
    end

    // Controller state and all registered outputs; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            wait_q     <= '0;
            op_wr_q    <= 1'b0;
            base_q     <= '0;
            rd_data_q  <= '0;
            ce_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            lane_n_q   <= 1'b1;
            dq_oe_q    <= 1'b0;
            dq_out_q   <= '0;
            sram_adr_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            wait_q     <= wait_d;
            op_wr_q    <= op_wr_d;
            base_q     <= base_d;
            rd_data_q  <= rd_data_d;
            ce_n_q     <= ce_n_d;
            we_n_q     <= we_n_d;
            oe_n_q     <= oe_n_d;
            lane_n_q   <= lane_n_d;
            dq_oe_q    <= dq_oe_d;
            dq_out_q   <= dq_out_d;
            sram_adr_q <= sram_adr_d;
        end
    end

    assign SRAM_DQ   = dq_oe_q ? dq_out_q : {SRAM_DW{1'bz}};
    assign SRAM_adr  = sram_adr_q;
    assign SRAM_CE_N = ce_n_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_OE_N = oe_n_q;
    assign SRAM_UB_N = lane_n_q;
    assign SRAM_LB_N = lane_n_q;
    assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Directed bench for mem_sram_ctrl with a behavioural async SRAM; a second
// instance runs WAIT_CYC=4. Posted-write expectations follow MEM_SRAM_CTRL_POST_WR_EN.
module tb_mem_sram_ctrl;

`ifdef MEM_SRAM_CTRL_POST_WR_EN
    localparam int WR_STALL = 0;
`else
    localparam int WR_STALL = 5;
`endif

    logic        clk;
    logic        rst;
    logic        wr_en, rd_en;
    logic [31:0] adr, wr_data, rd_data;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_adr;
    logic        sram_ub_n, sram_lb_n, sram_we_n, sram_ce_n, sram_oe_n;

    logic        wr_en4, rd_en4;
    logic [31:0] adr4, wr_data4, rd_data4;
    logic        ready4;
    wire  [15:0] sram_dq4;
    logic [17:0] sram_adr4;
    logic        ub4, lb4, we4, ce4, oe4;

    logic [15:0] mem [0:255];
    logic        mem_clr;

    int          vectors = 0;
    int          miscompares = 0;
    int          stall, we_lo, oe_lo, nlog;
    int          pulses, first_c, second_c;
    logic [17:0] log_adr [4];
    logic [15:0] log_dq  [4];

    mem_sram_ctrl u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .adr(adr), .wr_data(wr_data),
        .rd_data(rd_data), .ready(ready), .SRAM_DQ(sram_dq), .SRAM_adr(sram_adr),
        .SRAM_UB_N(sram_ub_n), .SRAM_LB_N(sram_lb_n), .SRAM_WE_N(sram_we_n),
        .SRAM_CE_N(sram_ce_n), .SRAM_OE_N(sram_oe_n)
    );

    mem_sram_ctrl #(.WAIT_CYC(4)) u_dut4 (
        .clk(clk), .rst(rst), .wr_en(wr_en4), .rd_en(rd_en4), .adr(adr4), .wr_data(wr_data4),
        .rd_data(rd_data4), .ready(ready4), .SRAM_DQ(sram_dq4), .SRAM_adr(sram_adr4),
        .SRAM_UB_N(ub4), .SRAM_LB_N(lb4), .SRAM_WE_N(we4),
        .SRAM_CE_N(ce4), .SRAM_OE_N(oe4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Async SRAM model: a write lands at the end of any cycle with CE_N and WE_N low.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
        end else if (!sram_ce_n && !sram_we_n) begin
            mem[sram_adr[7:0]] <= sram_dq;
        end
    end
    assign sram_dq  = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_adr[7:0]] : 16'hzzzz;
    assign sram_dq4 = (!ce4 && !oe4) ? {4'hC, sram_adr4[11:0]} : 16'hzzzz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request at a negedge (cycle 0) and hold it until ready, logging write beats.
    task automatic do_req(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        stall = 0; we_lo = 0; oe_lo = 0; nlog = 0;
        @(negedge clk);
        wr_en = w; rd_en = r; adr = a; wr_data = d;
        #1;
        while (ready !== 1'b1 && stall < 40) begin
            stall++;
            @(negedge clk);
            #1;
            if (sram_oe_n === 1'b0) oe_lo++;
            if (sram_we_n === 1'b0) begin
                we_lo++;
                if (nlog < 4) begin
                    log_adr[nlog] = sram_adr;
                    log_dq[nlog]  = sram_dq;
                    nlog++;
                end
            end
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic settle();
        repeat (8) @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; mem_clr = 1'b1;
        wr_en = 1'b0; rd_en = 1'b0; adr = 32'd0; wr_data = 32'd0;
        wr_en4 = 1'b0; rd_en4 = 1'b0; adr4 = 32'd0; wr_data4 = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ce_n", {31'd0, sram_ce_n}, 32'd1);
        check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
        check("rst_oe_n", {31'd0, sram_oe_n}, 32'd1);
        check("rst_lanes", {30'd0, sram_ub_n, sram_lb_n}, 32'd3);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_ready", {31'd0, ready}, 32'd1);
        @(negedge clk);
        rst = 1'b1; mem_clr = 1'b0;
        settle();

        do_req(1'b1, 1'b0, 32'd1032, 32'hDEAD_BEEF);
        check("wr_stall", stall, WR_STALL);
`ifndef MEM_SRAM_CTRL_POST_WR_EN
        check("wr_we_lo", we_lo, 32'd2);
        check("wr_adr0", {14'd0, log_adr[0]}, 32'd4);
        check("wr_dq0", {16'd0, log_dq[0]}, 32'h0000_BEEF);
        check("wr_adr1", {14'd0, log_adr[1]}, 32'd5);
        check("wr_dq1", {16'd0, log_dq[1]}, 32'h0000_DEAD);
`endif
        settle();

        do_req(1'b0, 1'b1, 32'd1032, 32'd0);
        check("rd_stall", stall, 32'd5);
        check("rd_oe_lo", oe_lo, 32'd4);
        check("rd_data", rd_data, 32'hDEAD_BEEF);
        settle();

        do_req(1'b1, 1'b1, 32'd1024, 32'h1234_5678);
        check("both_stall", stall, WR_STALL);
        settle();
        do_req(1'b0, 1'b1, 32'd1024, 32'd0);
        check("both_rdback", rd_data, 32'h1234_5678);
        settle();

        do_req(1'b1, 1'b0, 32'd1028, 32'h0BAD_F00D);
        settle();

        // Two reads with rd_en held through DONE: ready pulses in cycles 5 and 11.
        pulses = 0; first_c = -1; second_c = -1;
        @(negedge clk);
        rd_en = 1'b1; adr = 32'd1024;
        for (int c = 0; c < 30 && pulses < 2; c++) begin
            #1;
            if (ready === 1'b1) begin
                pulses++;
                if (pulses == 1) begin
                    first_c = c;
                    check("b2b_rd0", rd_data, 32'h1234_5678);
                    adr = 32'd1028;
                end else begin
                    second_c = c;
                    check("b2b_rd1", rd_data, 32'h0BAD_F00D);
                end
            end
            if (pulses < 2) @(negedge clk);
        end
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        check("b2b_pulses", pulses, 32'd2);
        check("b2b_first", first_c, 32'd5);
        check("b2b_second", second_c, 32'd11);
        settle();

        // Reset during the first write beat must abort before anything reaches the SRAM.
        @(negedge clk);
        wr_en = 1'b1; adr = 32'd1088; wr_data = 32'hCAFE_F00D;
        @(negedge clk);
        #1;
        check("midwr_we_n", {31'd0, sram_we_n}, 32'd0);
        rst = 1'b0; wr_en = 1'b0;
        #1;
        check("abort_ce_n", {31'd0, sram_ce_n}, 32'd1);
        check("abort_we_n", {31'd0, sram_we_n}, 32'd1);
        check("abort_oe_n", {31'd0, sram_oe_n}, 32'd1);
        check("abort_rd_data", rd_data, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        settle();
        do_req(1'b0, 1'b1, 32'd1088, 32'd0);
        check("abort_stall", stall, 32'd5);
        check("abort_rdback", rd_data, 32'd0);
        settle();

`ifdef MEM_SRAM_CTRL_POST_WR_EN
        @(negedge clk);
        wr_en = 1'b1; adr = 32'd1152; wr_data = 32'h5A5A_0FF0;
        #1;
        check("post_ready0", {31'd0, ready}, 32'd1);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        do_req(1'b0, 1'b1, 32'd1152, 32'd0);
        check("post_rd_stall", stall, 32'd10);
        check("post_rd_data", rd_data, 32'h5A5A_0FF0);
        settle();
`endif

        // WAIT_CYC=4 instance: 2 beats x 4 cycles of OE_N low, 9 stalled cycles.
        stall = 0; oe_lo = 0;
        @(negedge clk);
        rd_en4 = 1'b1; adr4 = 32'd1024;
        #1;
        while (ready4 !== 1'b1 && stall < 40) begin
            stall++;
            @(negedge clk);
            #1;
            if (oe4 === 1'b0) oe_lo++;
        end
        @(posedge clk);
        #1;
        rd_en4 = 1'b0;
        check("w4_stall", stall, 32'd9);
        check("w4_oe_lo", oe_lo, 32'd8);
        check("w4_rd_data", rd_data4, 32'hC001_C000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_sram_ctrl.md
# mem_sram_ctrl

Parametrised SRAM controller for the MEM stage: turns single-cycle `wr_en`/`rd_en` word requests into multi-beat, wait-stated accesses on an external asynchronous SRAM. Generalises the fixed 32-bit/16-bit controller in three ways:
- configurable data, SRAM and address widths;
- configurable wait states and base address;
- optional posted writes.

`ready` low freezes the pipeline until the access completes.

## Interface
- DATA_W, 32: processor word width; multiple of SRAM_DW
- SRAM_DW, 16: SRAM data bus width
- SRAM_AW, 18: SRAM address width
- WAIT_CYC, 2: cycles per SRAM beat, ≥1
- BASE_ADR, 1024: processor byte address mapped to SRAM word 0
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- wr_en  in  1  write request, held until `ready`
- rd_en  in  1  read request, held until `ready`
- adr  in  32  byte address, word aligned
- wr_data  in  DATA_W  write data
- rd_data  out  DATA_W  read data, registered
- ready  out  1  request complete / no stall
- SRAM_DQ  inout  SRAM_DW  SRAM data
- SRAM_adr  out  SRAM_AW  SRAM address
- SRAM_UB_N, SRAM_LB_N  out  1 each  byte lanes, active low
- SRAM_WE_N, SRAM_CE_N, SRAM_OE_N  out  1 each  active low

## Operation
- BEATS = DATA_W/SRAM_DW.
- Word index = (adr − BASE_ADR) >> 2.
- Beat i address = word·BEATS + i, truncated to SRAM_AW.
- Beat 0 carries the least-significant half.
- States:
  - IDLE: if wr_en or rd_en, latch op/adr/wr_data and go to ACCESS.
  - ACCESS: run BEATS×WAIT_CYC cycles, with `wait_cnt` nested inside `beat_cnt`; then go to DONE.
  - DONE: one cycle, then IDLE.
- `wr_en` and `rd_en` both high: write takes priority; read ignored.
- `ready = ~(wr_en | rd_en) | (state==DONE)`, combinational.
- In IDLE and DONE: CE_N=1, WE_N=1, OE_N=1, SRAM_DQ=Z.
- ACCESS write beat:
  - CE_N=0, UB_N=LB_N=0, OE_N=1.
  - DQ driven with slice i.
  - WE_N=0 on every cycle of the beat except the last (hold cycle).
- ACCESS read beat:
  - CE_N=0, OE_N=0, WE_N=1, DQ=Z.
  - rd_data slice i captured on the beat's last cycle.
- rd_data changes only on read capture and holds otherwise.
- Reset values:
  - state=IDLE, counters 0, rd_data 0.
  - CE_N/WE_N/OE_N/UB_N/LB_N = 1, DQ=Z.
  - ready follows the formula above.
- Reset asserted mid-access aborts immediately. A partial write is not completed.

## Timing
- Request first seen in IDLE at cycle 0.
- ACCESS occupies cycles 1..BEATS×WAIT_CYC.
- DONE falls in cycle BEATS×WAIT_CYC+1, where ready=1 and rd_data is valid.
- Stall length = BEATS×WAIT_CYC+1 cycles.
- A request still high after DONE is treated as a new request in the following IDLE cycle. Back-to-back accesses therefore have no extra bubble beyond IDLE.
- Requester holds adr, wr_data and the enables stable while ready=0. Changes during ACCESS are ignored because the values are latched.

## Configuration
- MEM_SRAM_CTRL_POST_WR_EN defined:
  - A write in IDLE with the buffer empty is latched into the write buffer. ready=1 that same cycle.
  - The SRAM write then proceeds in the background (ACCESS→DONE→IDLE as normal).
  - Any request, read or write, arriving while the buffer is busy sees ready=0 until the drain completes, then is served normally.
  - No read bypass from the buffer.
- Macro undefined: writes block exactly like reads, per Timing.

## Structure
- Package `mem_sram_pkg` holds:
  - state enum {IDLE, ACCESS, DONE};
  - `BEATS` derivation function;
  - default parameter constants.
- Sub-module `mem_sram_wbuf` (address+data register with valid flag) is instantiated only under MEM_SRAM_CTRL_POST_WR_EN.

## Test plan
All scenarios use default parameters.
- Reset: rst=0 mid-write → CE_N=WE_N=OE_N=1, DQ=Z, rd_data=0 next edge.
- Write then read, adr=1024+8, wr_data=32'hDEAD_BEEF:
  - write: ready low 5 cycles; SRAM_adr 4 then 5; DQ 16'hBEEF then 16'hDEAD; WE_N low 1 cycle per beat.
  - read back returns 32'hDEAD_BEEF on ready.
- WAIT_CYC=4 read: ready low exactly 9 cycles; OE_N low 8 cycles.
- wr_en=rd_en=1 at adr=1024, wr_data=32'h1234_5678 → write performed; subsequent read returns 32'h1234_5678.
- Enables held through DONE: two consecutive reads of adr 1024, 1028 → 11 total cycles, two ready pulses.
- POST_WR_EN: write at cycle 0 → ready=1 at cycle 0. Read at cycle 1 → ready low until write drains (cycle 5), then 5 more cycles.
